// File: rtl/data_mem_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_mmio
//  Purpose  : Data-side memory stage for a single-cycle core. Decodes the
//             core's byte address into word RAM and a small MMIO page
//             (LED register, 8N1 UART transmitter, free-running cycle
//             counter) and returns load data combinationally.
//  Ports    : clk        - system clock, all state on rising edge
//             reset      - asynchronous active-high reset
//             mem_write  - store strobe from core
//             addr       - byte address (addr[1:0] ignored, word access)
//             write_data - store data from core
//             read_data  - load data, combinational from addr and state
//             leds       - LED register value
//             uart_tx    - UART serial output, idle high
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_mmio #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          CLK_DIV     = 868,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [7:0]  leds,
  output logic        uart_tx
);

  localparam int          RAM_AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam int          BAUD_W    = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

  localparam logic [31:0] LED_ADDR    = MMIO_BASE + 32'h0;
  localparam logic [31:0] TXDATA_ADDR = MMIO_BASE + 32'h4;
  localparam logic [31:0] STATUS_ADDR = MMIO_BASE + 32'h8;
  localparam logic [31:0] CYCLES_ADDR = MMIO_BASE + 32'hC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // --------------------------------------------------------------------------
  // Address decode (byte offset bits do not participate)
  // --------------------------------------------------------------------------
  logic [31:0]       word_addr;
  logic [1:0]        unused_addr_lsbs;
  logic              is_ram, is_led, is_txdata, is_status, is_cycles;
  logic [RAM_AW-1:0] ram_idx;

  assign word_addr        = {addr[31:2], 2'b00};
  assign unused_addr_lsbs = addr[1:0];
  assign is_ram           = (word_addr < RAM_BYTES);
  assign is_led           = (word_addr == LED_ADDR);
  assign is_txdata        = (word_addr == TXDATA_ADDR);
  assign is_status        = (word_addr == STATUS_ADDR);
  assign is_cycles        = (word_addr == CYCLES_ADDR);
  assign ram_idx          = addr[RAM_AW+1:2];

  // --------------------------------------------------------------------------
  // Word RAM: contents are deliberately not reset
  // --------------------------------------------------------------------------
  logic [31:0] ram_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (mem_write && is_ram) begin
      ram_q[ram_idx] <= write_data;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [7:0]        leds_q,    leds_d;
  logic [31:0]       cycles_q,  cycles_d;
  uart_state_e       state_q,   state_d;
  logic [BAUD_W-1:0] baud_q,    baud_d;
  logic [2:0]        bit_q,     bit_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              busy;

  assign busy = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_q    <= '0;
      cycles_q  <= '0;
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      tx_byte_q <= '0;
    end else begin
      leds_q    <= leds_d;
      cycles_q  <= cycles_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    leds_d    = leds_q;
    cycles_d  = cycles_q + 32'd1;
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    tx_byte_d = tx_byte_q;

    if (mem_write && is_led) begin
      leds_d = write_data[7:0];
    end

    // A store to CYCLES overrides the increment on the same edge.
    if (mem_write && is_cycles) begin
      cycles_d = '0;
    end

    // TXDATA stores are only honoured in IDLE; anything else is dropped,
    // including a store on the very edge that finishes a frame.
    case (state_q)
      ST_IDLE: begin
        if (mem_write && is_txdata) begin
          tx_byte_d = write_data[7:0];
          state_d   = ST_START;
          baud_d    = '0;
          bit_d     = '0;
        end
      end
      ST_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: serial line is decoded from state so reset drives it high at once
  // --------------------------------------------------------------------------
  always_comb begin
    uart_tx = 1'b1;
    case (state_q)
      ST_START: uart_tx = 1'b0;
      ST_DATA:  uart_tx = tx_byte_q[bit_q];
      default:  uart_tx = 1'b1;
    endcase
  end

  assign leds = leds_q;

  always_comb begin
    read_data = '0;
    if (is_ram) begin
      read_data = ram_q[ram_idx];
    end else if (is_led) begin
      read_data = {24'b0, leds_q};
    end else if (is_status) begin
      read_data = {31'b0, busy};
    end else if (is_cycles) begin
      read_data = cycles_q;
    end
  end

endmodule
`default_nettype wire
